fir_filter_core: RTL and testbench
==================================

# fir_filter_core

Fixed-coefficient, 16-tap, direct-form low-pass FIR filter for 16-bit signed audio sampled at 48 kHz. It accepts one new sample on every clock and produces one full-precision 32-bit signed result per clock, with no handshake. It sits between the audio sample source and downstream gain/requantisation logic. Constant-coefficient arithmetic guarantees that a full-scale input never overflows the output.

## Interface
- DATA_WIDTH, 16: input sample width, two's complement.
- COEF_WIDTH, 16: coefficient width, signed Q1.15.
- TAPS, 16: number of taps.
- OUT_WIDTH, 32: output width, signed.
- clk  input  1  sample clock; one sample per rising edge (48 kHz nominal).
- rst  input  1  reset, asynchronous, active-low.
- data_in  input  DATA_WIDTH  signed sample, sampled on every rising clk edge.
- data_out  output  OUT_WIDTH  signed filter result, registered.

## Operation
- Coefficients h0..h15: 128, 384, 768, 1280, 2048, 2944, 3712, 5120, 5120, 3712, 2944, 2048, 1280, 768, 384, 128.
  - Symmetric (linear phase).
  - Sum is 32768, giving unity DC gain in Q15.
- Delay line x[0..15]: on each edge, x[0] <= data_in and x[i] <= x[i-1].
- y = Σ h[i]·x[i]. Products are full 32-bit signed. The sum is accumulated at 36 bits (log2 TAPS guard bits).
- data_out <= sat32(y). Saturate to +2^31-1 / -2^31 if the 36-bit sum exceeds 32-bit range. This is unreachable with the default coefficients but required if the coefficients are overridden.
- The pre-add of symmetric pairs (x[i]+x[15-i], 17 bits) is permitted and must give identical results.
- No scaling or rounding: data_out is exact Q(16+15) fixed point.
- While rst is low, all delay-line registers and data_out are 0 immediately, without waiting for a clock. Release is synchronous to the next edge.

## Timing
- Latency: a sample present before edge k enters x[0] at edge k. Its h0 contribution appears on data_out after edge k+1 (2 edges).
- Throughput: 1 sample/clock; no stall or valid signal.
- After reset release, data_out reflects zero history. Outputs are fully settled 17 edges after the first non-zero sample.
- Reset asserted mid-stream: history is lost, and data_out = 0 until new samples propagate.
- Any additional internal pipelining is forbidden; latency is exactly 2.

## Structure
- Package fir_pkg holds:
  - DATA_WIDTH, COEF_WIDTH, TAPS, ACC_WIDTH (36), OUT_WIDTH.
  - The coefficient constant array.
  - The saturation function.
- One sub-module, fir_adder_tree: a combinational sum of TAPS signed products to ACC_WIDTH.
- The top level holds the delay line, the multipliers (constant operands) and the output register.

## Test plan
- Reset: hold rst low with data_in = 0x7FFF and clk running -> data_out = 0 throughout. Assert rst low asynchronously mid-stream -> data_out is 0 before the next edge.
- Impulse: data_in = 1 for one sample, otherwise 0 -> data_out = 128, 384, 768, 1280, 2048, 2944, 3712, 5120, 5120, … , 128 on 16 consecutive cycles starting 2 edges after the sample, then 0.
- Positive full-scale step (overflow check): data_in = 0x7FFF constant for 48000 cycles -> monotonic ramp settling to 1073709056 (0x3FFF8000), held exactly, never wrapping negative.
- Negative full-scale step: data_in = 0x8000 constant -> settles to -1073741824 (0xC0000000), no wrap.
- Alternating ±0x7FFF at Nyquist -> steady-state |data_out| = 32767·|Σ(-1)^i h_i| = 0, since the symmetric alternating sum cancels. The first 16 outputs must match the golden model.
- Random 16-bit input, 10k samples -> bit-exact match with the golden convolution model at 2-cycle latency.

Source files
------------

// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fir_pkg
// Description : Shared widths, coefficient set and output saturation helper
//               for the 16-tap fixed-coefficient low-pass FIR filter.
// Revision    : 1.0 - initial release
// ============================================================================
package fir_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int COEF_WIDTH = 16;
  localparam int TAPS       = 16;
  localparam int PROD_WIDTH = DATA_WIDTH + COEF_WIDTH;
  // Four guard bits above the product width so that sixteen products can
  // never wrap the accumulator.
  localparam int ACC_WIDTH  = PROD_WIDTH + $clog2(TAPS);
  localparam int OUT_WIDTH  = 32;

  typedef logic signed [COEF_WIDTH-1:0] coef_t;

  // Symmetric Q1.15 low-pass kernel; the taps sum to 32768 (unity DC gain).
  localparam coef_t COEFS [TAPS] = '{
    16'sd128,  16'sd384,  16'sd768,  16'sd1280,
    16'sd2048, 16'sd2944, 16'sd3712, 16'sd5120,
    16'sd5120, 16'sd3712, 16'sd2944, 16'sd2048,
    16'sd1280, 16'sd768,  16'sd384,  16'sd128
  };

  // Clamp the wide accumulator into the output range. The sum fits when all
  // bits from the output sign bit upward are copies of the accumulator sign.
  function automatic logic signed [OUT_WIDTH-1:0] sat_out(
    input logic signed [ACC_WIDTH-1:0] acc
  );
    logic [ACC_WIDTH-OUT_WIDTH:0] upper;
    upper = acc[ACC_WIDTH-1:OUT_WIDTH-1];
    if ((upper == '0) || (upper == '1)) begin
      return acc[OUT_WIDTH-1:0];
    end else if (acc[ACC_WIDTH-1]) begin
      return {1'b1, {(OUT_WIDTH-1){1'b0}}};
    end else begin
      return {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/fir_adder_tree.sv
`default_nettype none
// ============================================================================
// Module      : fir_adder_tree
// Description : Purely combinational signed sum of TAPS full-width products,
//               each sign-extended to the accumulator width before adding.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_adder_tree
  import fir_pkg::*;
(
  input  logic signed [PROD_WIDTH-1:0] i_prods [TAPS],
  output logic signed [ACC_WIDTH-1:0]  o_sum
);

  logic signed [ACC_WIDTH-1:0] w_ext [TAPS];
  logic signed [ACC_WIDTH-1:0] w_acc;

  // Sign-extend every product to the accumulator width.
  generate
    for (genvar g = 0; g < TAPS; g++) begin : g_ext
      assign w_ext[g] = {{(ACC_WIDTH-PROD_WIDTH){i_prods[g][PROD_WIDTH-1]}}, i_prods[g]};
    end
  endgenerate

  // Sum all extended products; synthesis is free to balance the adders.
  always_comb begin
    w_acc = '0;
    for (int i = 0; i < TAPS; i++) begin
      w_acc = w_acc + w_ext[i];
    end
  end

  assign o_sum = w_acc;

endmodule
`default_nettype wire

// File: rtl/fir_filter_core.sv
`default_nettype none
// ============================================================================
// Module      : fir_filter_core
// Description : 16-tap direct-form FIR filter. One sample in and one exact
//               32-bit result out per clock; two-edge input-to-output latency.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_filter_core
  import fir_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,       // active-low, asynchronous
  input  logic signed [DATA_WIDTH-1:0] data_in,
  output logic signed [OUT_WIDTH-1:0]  data_out
);

  logic signed [DATA_WIDTH-1:0] r_x [TAPS];
  logic signed [PROD_WIDTH-1:0] w_prod [TAPS];
  logic signed [ACC_WIDTH-1:0]  w_sum;
  logic signed [OUT_WIDTH-1:0]  r_data_out;

  // Delay line: newest sample in tap 0, everything shifts by one each edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < TAPS; i++) begin
        r_x[i] <= '0;
      end
    end else begin
      r_x[0] <= data_in;
      for (int i = 1; i < TAPS; i++) begin
        r_x[i] <= r_x[i-1];
      end
    end
  end

  // Constant-operand multipliers; operands are widened first so the product
  // is formed at full width (-32768 * -32768 still fits in 32 bits).
  generate
    for (genvar g = 0; g < TAPS; g++) begin : g_tap
      assign w_prod[g] = PROD_WIDTH'(r_x[g]) * PROD_WIDTH'(COEFS[g]);
    end
  endgenerate

  fir_adder_tree u_adder_tree (
    .i_prods (w_prod),
    .o_sum   (w_sum)
  );

  // Output register: the only stage after the delay line, keeps latency at 2.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data_out <= '0;
    end else begin
      r_data_out <= sat_out(w_sum);
    end
  end

  assign data_out = r_data_out;

endmodule
`default_nettype wire

// File: tb/tb_fir_filter_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_filter_core
// Description : Self-checking bench for fir_filter_core with a convolution
//               reference model feeding a scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_filter_core;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic signed [15:0] data_in = '0;
  logic signed [31:0] data_out;

  fir_filter_core dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int h [16] = '{128, 384, 768, 1280, 2048, 2944, 3712, 5120,
                 5120, 3712, 2944, 2048, 1280, 768, 384, 128};
  int hist [16];
  logic signed [31:0] sb [$];
  logic signed [31:0] prev;
  logic [31:0] rnd;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference convolution over the bench's own sample history.
  task automatic model_push(input int v);
    longint acc;
    for (int i = 15; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = v;
    acc = 0;
    for (int i = 0; i < 16; i++) acc += longint'(h[i]) * longint'(hist[i]);
    if (acc > 64'sd2147483647) acc = 64'sd2147483647;
    if (acc < -64'sd2147483648) acc = -64'sd2147483648;
    sb.push_back(acc[31:0]);
  endtask

  // Drive one sample, clock it in, and score the result that emerges now
  // (the one belonging to the sample driven one step earlier).
  task automatic step(input string tag, input logic signed [15:0] v);
    data_in = v;
    model_push(int'(v));
    @(posedge clk);
    #1;
    if (sb.size() > 1) check(tag, data_out, sb.pop_front());
  endtask

  // Asynchronous assertion between edges, synchronous release.
  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_async", data_out, 32'sd0);
    sb.delete();
    for (int i = 0; i < 16; i++) hist[i] = 0;
    @(posedge clk);
    #1;
    check("rst_held", data_out, 32'sd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) hist[i] = 0;
    data_in = 16'sh7FFF;
    #2 rst = 1'b0;

    // Reset held with full-scale input and clock running.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("rst_hold", data_out, 32'sd0);
    end
    rst = 1'b1;

    // Impulse response.
    step("impulse", 16'sd1);
    for (int i = 0; i < 20; i++) step("impulse", 16'sd0);

    // Positive full-scale step: monotonic rise to 0x3FFF8000.
    prev = '0;
    for (int i = 0; i < 48000; i++) begin
      step("pos_step", 16'sh7FFF);
      if (i < 40) begin
        checks++;
        assert (data_out >= prev) else begin
          errors++;
          $error("FAIL pos_mono: observed %0d expected >= %0d", data_out, prev);
        end
        prev = data_out;
      end
    end
    check("pos_final", data_out, 32'sd1073709056);

    // Reset while the output is large.
    pulse_reset();

    // Negative full-scale step.
    for (int i = 0; i < 100; i++) step("neg_step", 16'sh8000);
    check("neg_final", data_out, -32'sd1073741824);

    // Nyquist alternation from zero history.
    pulse_reset();
    for (int i = 0; i < 60; i++) step("nyquist", (i % 2 == 0) ? 16'sh7FFF : 16'sh8001);
    check("nyq_steady", data_out, 32'sd0);

    // Random samples.
    for (int i = 0; i < 10000; i++) begin
      rnd = $urandom();
      step("random", rnd[15:0]);
    end
    step("drain", 16'sd0);
    step("drain", 16'sd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
